mac_operand_feeder: RTL and testbench
=====================================

Name: mac_operand_feeder

Overview:
- Transmit-side companion to the 5-tap `mac` datapath in the BDD accelerator.
- Holds the five coefficient registers c1..c5 and builds a sliding 5-sample operand window A1..A5 from an incoming 8-bit sample stream.
- Presents each complete window, with the coefficients, to the MAC over a valid/ready handshake.
- Sits between the sample source (memory/DMA stream) and `mac`.

Parameters:
DATA_W, 8, width of each sample and coefficient
TAPS, 5, window depth and coefficient count; fixed at 5 to match `mac`

Ports:
clk  input  1  single clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
coef_we  input  1  coefficient write strobe
coef_addr  input  3  coefficient index 0..4 (0 -> c1)
coef_wdata  input  DATA_W  coefficient value
start  input  1  one-cycle pulse that begins a frame
s_valid  input  1  sample valid
s_ready  output  1  sample accepted when s_valid&&s_ready
s_data  input  DATA_W  sample
s_last  input  1  marks the final sample of a frame
m_valid  output  1  operand window valid toward `mac`
m_ready  input  1  `mac` accepts window
m_last  output  1  window contains the frame's last sample
a_bus  output  TAPS*DATA_W  A1 at [7:0] (newest) .. A5 at [39:32] (oldest)
c_bus  output  TAPS*DATA_W  c1 at [7:0] .. c5 at [39:32]
done  output  1  one-cycle pulse when the last window is accepted
err  output  1  sticky short-frame error, cleared by start

Behaviour:
- Reset (rst=1 at an edge): state=IDLE; a_bus, c_bus, fill count = 0; m_valid, m_last, done, err, s_ready = 0.
- Reset mid-frame aborts the frame with no done pulse.
- States: IDLE, FILL, STREAM, DRAIN.
- IDLE:
  - s_ready=0.
  - coef_we writes c[coef_addr]; addr 5..7 is ignored.
  - coef_we outside IDLE is ignored.
  - start -> FILL; window cleared to 0, count=0, err=0.
- Accepted sample: window shifts A5<=A4, A4<=A3, A3<=A2, A2<=A1, A1<=s_data.
- FILL:
  - s_ready=1, m_valid=0; count increments per accepted sample.
  - On accept with count==TAPS-1: go to STREAM, m_valid<=1, m_last<=s_last; if s_last, go to DRAIN instead.
  - s_last accepted with count<TAPS-1: err<=1 -> IDLE; no window emitted, no done.
- STREAM:
  - s_ready = !m_valid || m_ready (single-entry skid).
  - Accept without handshake: m_valid<=1.
  - Handshake (m_valid&&m_ready) without accept: m_valid<=0.
  - Both in the same cycle: m_valid stays 1 with the new window.
  - Accepted s_last: m_last<=1 -> DRAIN.
- DRAIN:
  - s_ready=0.
  - On handshake: m_valid<=0, m_last<=0, done=1 for one cycle -> IDLE.
- start outside IDLE is ignored.
- Throughput: one window per cycle with m_ready held high.
- Latency: sample accept to m_valid is 1 cycle.
- a_bus/c_bus stay stable while m_valid && !m_ready.
- No arithmetic in this block; widths are pass-through.

Decomposition:
- Shared package `mac_pkg`:
  - DATA_W and TAPS constants
  - feeder state enum (IDLE/FILL/STREAM/DRAIN)
  - packed type for the operand window bus (TAPS x DATA_W)
- Sub-module `tap_shift_reg`: TAPS-deep DATA_W shift register with shift-enable and clear; reused later for the result-side delay line.

Test Plan:
- Reset then coef writes addr0..4 = 1,2,3,4,5, plus addr 6 = 9 -> c_bus = 0x0504030201; addr 6 has no effect.
- Start, stream samples 1..7 with m_ready=1, s_last on 7 -> three windows:
  - a_bus 0x0102030405
  - a_bus 0x0203040506
  - a_bus 0x0304050607, with m_last=1
  - done pulses one cycle after the third handshake.
- Same frame with m_ready held 0 after the first window for 4 cycles -> s_ready=0, a_bus stable at 0x0102030405; resumes with no sample lost.
- Short frame of 3 samples (s_last on the 3rd) -> m_valid never asserts, err=1, state IDLE; next start clears err.
- rst pulsed while in STREAM with m_valid=1 -> next cycle m_valid=0, a_bus=0, c_bus=0, no done.
- coef_we in STREAM with addr0 = 0xFF -> c1 unchanged.

Source files
------------

// File: rtl/mac_pkg.sv
// rtl/mac_pkg.sv - shared constants and types for the mac operand path
package mac_pkg;

    localparam int DATA_W = 8;
    localparam int TAPS   = 5;
    localparam int WIN_W  = TAPS * DATA_W;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FILL   = 2'd1,
        ST_STREAM = 2'd2,
        ST_DRAIN  = 2'd3
    } feeder_state_e;

    // Element 0 is tap 1 (newest sample / c1), element TAPS-1 is tap TAPS.
    typedef logic [TAPS-1:0][DATA_W-1:0] window_t;

endpackage

// File: rtl/tap_shift_reg.sv
// rtl/tap_shift_reg.sv - DEPTH-deep WIDTH-bit shift register with shift-enable and clear
//
// Ports:
//   clk_i       clock
//   rst_i       synchronous active-high reset (clears all taps)
//   clr_i       synchronous clear, has priority over shift_en_i
//   shift_en_i  shift din_i into tap 1, older taps move one place up
//   din_i       new sample
//   taps_o      tap 1 at [WIDTH-1:0] .. tap DEPTH in the top WIDTH bits
module tap_shift_reg #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 5
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   clr_i,
    input  logic                   shift_en_i,
    input  logic [WIDTH-1:0]       din_i,
    output logic [DEPTH*WIDTH-1:0] taps_o
);

    logic [DEPTH*WIDTH-1:0] taps_q;
    logic [DEPTH*WIDTH-1:0] taps_d;

    always_comb begin
        taps_d = taps_q;
        if (clr_i) begin
            taps_d = '0;
        end else if (shift_en_i) begin
            taps_d = {taps_q[(DEPTH-1)*WIDTH-1:0], din_i};
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            taps_q <= '0;
        end else begin
            taps_q <= taps_d;
        end
    end

    assign taps_o = taps_q;

endmodule

// File: rtl/mac_operand_feeder.sv
// rtl/mac_operand_feeder.sv - builds sliding 5-sample operand windows plus coefficients for the mac datapath
//
// Ports:
//   clk_i, rst_i         clock, synchronous active-high reset
//   coef_we_i/addr/wdata coefficient write port (IDLE only, addr 0..TAPS-1)
//   start_i              begins a frame (IDLE only)
//   s_valid_i/s_ready_o/s_data_i/s_last_i   sample stream in
//   m_valid_o/m_ready_i/m_last_o            window handshake toward mac
//   a_bus_o              A1 (newest) at [7:0] .. A5 (oldest) at the top
//   c_bus_o              c1 at [7:0] .. c5 at the top
//   done_o               one-cycle pulse after the final window is taken
//   err_o                sticky short-frame flag, cleared by start
module mac_operand_feeder
    import mac_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              coef_we_i,
    input  logic [2:0]        coef_addr_i,
    input  logic [DATA_W-1:0] coef_wdata_i,
    input  logic              start_i,
    input  logic              s_valid_i,
    output logic              s_ready_o,
    input  logic [DATA_W-1:0] s_data_i,
    input  logic              s_last_i,
    output logic              m_valid_o,
    input  logic              m_ready_i,
    output logic              m_last_o,
    output logic [WIN_W-1:0]  a_bus_o,
    output logic [WIN_W-1:0]  c_bus_o,
    output logic              done_o,
    output logic              err_o
);

    localparam logic [2:0] CNT_LAST = 3'(TAPS - 1);

    feeder_state_e state_q, state_d;
    logic [2:0]    count_q, count_d;
    logic          m_valid_q, m_valid_d;
    logic          m_last_q, m_last_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    window_t       coef_q;

    logic          s_ready;
    logic          accept;
    logic          handshake;
    logic          win_clr;

    // In STREAM the output register doubles as a one-entry skid: a new
    // sample may only land when the current window is gone or leaving.
    assign s_ready   = (state_q == ST_FILL) ||
                       ((state_q == ST_STREAM) && (!m_valid_q || m_ready_i));
    assign accept    = s_valid_i && s_ready;
    assign handshake = m_valid_q && m_ready_i;

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        m_valid_d = m_valid_q;
        m_last_d  = m_last_q;
        err_d     = err_q;
        done_d    = 1'b0;
        win_clr   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d = ST_FILL;
                    win_clr = 1'b1;
                    count_d = '0;
                    err_d   = 1'b0;
                end
            end

            ST_FILL: begin
                if (accept) begin
                    count_d = count_q + 3'd1;
                    if (count_q == CNT_LAST) begin
                        m_valid_d = 1'b1;
                        m_last_d  = s_last_i;
                        state_d   = s_last_i ? ST_DRAIN : ST_STREAM;
                    end else if (s_last_i) begin
                        // frame ended before a full window existed
                        err_d   = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            end

            ST_STREAM: begin
                if (accept) begin
                    m_valid_d = 1'b1;
                    if (s_last_i) begin
                        m_last_d = 1'b1;
                        state_d  = ST_DRAIN;
                    end
                end else if (handshake) begin
                    m_valid_d = 1'b0;
                end
            end

            ST_DRAIN: begin
                if (handshake) begin
                    m_valid_d = 1'b0;
                    m_last_d  = 1'b0;
                    done_d    = 1'b1;
                    state_d   = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            count_q   <= '0;
            m_valid_q <= 1'b0;
            m_last_q  <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            m_valid_q <= m_valid_d;
            m_last_q  <= m_last_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    // Coefficients are frozen for the whole frame; writes only land in IDLE.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            coef_q <= '0;
        end else if ((state_q == ST_IDLE) && coef_we_i && (coef_addr_i < 3'(TAPS))) begin
            coef_q[coef_addr_i] <= coef_wdata_i;
        end
    end

    tap_shift_reg #(
        .WIDTH (DATA_W),
        .DEPTH (TAPS)
    ) u_window (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .clr_i      (win_clr),
        .shift_en_i (accept),
        .din_i      (s_data_i),
        .taps_o     (a_bus_o)
    );

    assign s_ready_o = s_ready;
    assign m_valid_o = m_valid_q;
    assign m_last_o  = m_last_q;
    assign c_bus_o   = coef_q;
    assign done_o    = done_q;
    assign err_o     = err_q;

endmodule

// File: tb/tb_mac_operand_feeder.sv
// tb/tb_mac_operand_feeder.sv - self-checking bench for mac_operand_feeder
module tb_mac_operand_feeder;
    import mac_pkg::*;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              coef_we = 1'b0;
    logic [2:0]        coef_addr = '0;
    logic [DATA_W-1:0] coef_wdata = '0;
    logic              start = 1'b0;
    logic              s_valid = 1'b0;
    logic              s_ready;
    logic [DATA_W-1:0] s_data = '0;
    logic              s_last = 1'b0;
    logic              m_valid;
    logic              m_ready = 1'b0;
    logic              m_last;
    logic [WIN_W-1:0]  a_bus;
    logic [WIN_W-1:0]  c_bus;
    logic              done;
    logic              err;

    int checks = 0;
    int errors = 0;

    localparam logic [WIN_W-1:0] COEF_EXP = 40'h0504030201;

    always #5 clk = ~clk;

    mac_operand_feeder dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .coef_we_i    (coef_we),
        .coef_addr_i  (coef_addr),
        .coef_wdata_i (coef_wdata),
        .start_i      (start),
        .s_valid_i    (s_valid),
        .s_ready_o    (s_ready),
        .s_data_i     (s_data),
        .s_last_i     (s_last),
        .m_valid_o    (m_valid),
        .m_ready_i    (m_ready),
        .m_last_o     (m_last),
        .a_bus_o      (a_bus),
        .c_bus_o      (c_bus),
        .done_o       (done),
        .err_o        (err)
    );

    task automatic write_coef(input logic [2:0] addr, input logic [DATA_W-1:0] val);
        @(negedge clk);
        coef_we = 1'b1; coef_addr = addr; coef_wdata = val;
        @(negedge clk);
        coef_we = 1'b0;
    endtask

    task automatic load_coefs();
        for (int i = 0; i < TAPS; i++) write_coef(3'(i), 8'(i + 1));
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_m_valid actual=%b required=0", m_valid); end
        checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL reset_s_ready actual=%b required=0", s_ready); end
        checks++; if (a_bus !== '0) begin errors++; $display("FAIL reset_a_bus actual=%h required=0", a_bus); end
        checks++; if (c_bus !== '0) begin errors++; $display("FAIL reset_c_bus actual=%h required=0", c_bus); end
        checks++; if ({m_last, done, err} !== 3'b000) begin errors++; $display("FAIL reset_flags actual=%b required=000", {m_last, done, err}); end
        rst = 1'b0;
    endtask

    task automatic test_coef();
        load_coefs();
        write_coef(3'd6, 8'd9);
        #1;
        checks++; if (c_bus !== COEF_EXP) begin errors++; $display("FAIL coef_write actual=%h required=%h", c_bus, COEF_EXP); end
    endtask

    // Runs one frame of samples 1..n. stall_len holds m_ready low for that many
    // cycles from the first window; rnd randomises s_valid and m_ready.
    task automatic run_frame(input string name, input int n, input int stall_len, input bit rnd);
        logic [WIN_W-1:0] mwin = '0;
        logic [WIN_W:0]   exp_q[$];
        logic [WIN_W:0]   e;
        int  mcnt = 0;
        int  sent = 0;
        int  stall = 0;
        int  cyc = 0;
        int  tail = 0;
        int  pops = 0;
        bit  stall_used = 1'b0;
        bit  stalling;
        bit  done_pend = 1'b0;
        bit  got_done = 1'b0;
        bit  full = (n >= TAPS);

        @(negedge clk);
        start = 1'b1;
        while (1) begin
            @(negedge clk);
            start = 1'b0;
            if (stall_len > 0 && !stall_used && m_valid) begin
                stall = stall_len;
                stall_used = 1'b1;
            end
            stalling = (stall > 0);
            if (stalling) begin
                m_ready = 1'b0;
                stall--;
            end else begin
                m_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            if (sent < n) begin
                s_valid = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
                s_data  = 8'(sent + 1);
                s_last  = (sent == n - 1);
            end else begin
                s_valid = 1'b0; s_data = '0; s_last = 1'b0;
            end
            #1;
            if (cyc == 0) begin
                checks++; if (err !== 1'b0) begin errors++; $display("FAIL %s err_clear actual=%b required=0", name, err); end
            end
            if (stalling) begin
                checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL %s stall_s_ready actual=%b required=0", name, s_ready); end
                checks++;
                if (exp_q.size() == 0 || a_bus !== exp_q[0][WIN_W-1:0]) begin
                    errors++; $display("FAIL %s stall_a_bus actual=%h required=%h", name, a_bus, (exp_q.size() != 0) ? exp_q[0][WIN_W-1:0] : '0);
                end
            end
            checks++;
            if (done_pend) begin
                if (done !== 1'b1) begin errors++; $display("FAIL %s done_pulse actual=%b required=1", name, done); end
                done_pend = 1'b0;
                got_done = 1'b1;
            end else if (done !== 1'b0) begin
                errors++; $display("FAIL %s stray_done actual=%b required=0", name, done);
            end
            if (m_valid && m_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL %s unexpected_window actual=%h required=none", name, a_bus);
                end else begin
                    e = exp_q.pop_front();
                    pops++;
                    if (a_bus !== e[WIN_W-1:0] || m_last !== e[WIN_W]) begin
                        errors++; $display("FAIL %s window actual=%h/%b required=%h/%b", name, a_bus, m_last, e[WIN_W-1:0], e[WIN_W]);
                    end
                    if (e[WIN_W]) done_pend = 1'b1;
                end
            end
            if (s_valid && s_ready) begin
                mwin = {mwin[WIN_W-DATA_W-1:0], s_data};
                mcnt++;
                if (mcnt >= TAPS) exp_q.push_back({s_last, mwin});
                sent++;
            end
            cyc++;
            if (full && got_done) break;
            if (!full && sent == n) begin
                tail++;
                if (tail > 3) break;
            end
            if (cyc >= 400) begin
                checks++; errors++;
                $display("FAIL %s timeout actual=%0d required<400", name, cyc);
                break;
            end
        end
        s_valid = 1'b0; s_last = 1'b0;
        checks++;
        if (exp_q.size() != 0 || (full && pops != n - TAPS + 1)) begin
            errors++; $display("FAIL %s window_count actual=%0d required=%0d", name, pops, full ? n - TAPS + 1 : 0);
        end
        if (full && stall_len == 0 && !rnd) begin
            checks++; if (cyc != n + 2) begin errors++; $display("FAIL %s throughput actual=%0d required=%0d", name, cyc, n + 2); end
        end
        @(negedge clk);
        #1;
        checks++; if (done !== 1'b0 || s_ready !== 1'b0) begin errors++; $display("FAIL %s idle_after actual=%b%b required=00", name, done, s_ready); end
        checks++; if (err !== !full) begin errors++; $display("FAIL %s err_flag actual=%b required=%b", name, err, !full); end
        checks++; if (c_bus !== COEF_EXP) begin errors++; $display("FAIL %s c_bus actual=%h required=%h", name, c_bus, COEF_EXP); end
    endtask

    task automatic test_stream();
        run_frame("stream", 7, 0, 1'b0);
    endtask

    task automatic test_backpressure();
        run_frame("backpressure", 7, 4, 1'b0);
    endtask

    task automatic test_short_frame();
        run_frame("short", 3, 0, 1'b0);
    endtask

    task automatic test_coef_locked_and_reset();
        @(negedge clk);
        start = 1'b1;
        m_ready = 1'b0;
        for (int i = 0; i < TAPS; i++) begin
            @(negedge clk);
            start = 1'b0;
            s_valid = 1'b1; s_data = 8'(i + 1); s_last = 1'b0;
        end
        @(negedge clk);
        s_valid = 1'b0;
        coef_we = 1'b1; coef_addr = 3'd0; coef_wdata = 8'hFF;
        #1;
        checks++; if (m_valid !== 1'b1 || a_bus !== 40'h0102030405) begin errors++; $display("FAIL locked_window actual=%b/%h required=1/0102030405", m_valid, a_bus); end
        @(negedge clk);
        coef_we = 1'b0;
        #1;
        checks++; if (c_bus !== COEF_EXP) begin errors++; $display("FAIL coef_locked actual=%h required=%h", c_bus, COEF_EXP); end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL midrst_m_valid actual=%b required=0", m_valid); end
        checks++; if (a_bus !== '0 || c_bus !== '0) begin errors++; $display("FAIL midrst_buses actual=%h/%h required=0/0", a_bus, c_bus); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            checks++; if (done !== 1'b0 || m_valid !== 1'b0) begin errors++; $display("FAIL midrst_no_done actual=%b%b required=00", done, m_valid); end
        end
    endtask

    task automatic test_back_to_back();
        load_coefs();
        run_frame("exact5", 5, 0, 1'b0);
        run_frame("random", 20, 0, 1'b1);
        run_frame("after_random", 8, 0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_coef();
        test_stream();
        test_backpressure();
        test_short_frame();
        test_stream();
        test_coef_locked_and_reset();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
